// File: rtl/agp32_mem_seq_pkg.sv
// Shared types for the agp32 memory/accelerator/interrupt sequencer.
// Holds the bus command codes, request op codes, FSM states and a width helper.
package agp32_mem_seq_pkg;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_REFRESH   = 3'd1,
    CMD_READ      = 3'd2,
    CMD_WRITE     = 3'd3,
    CMD_INTERRUPT = 3'd4
  } cmd_t;

  typedef enum logic [2:0] {
    OP_NONE       = 3'd0,
    OP_LOAD       = 3'd1,
    OP_LOAD_BYTE  = 3'd2,
    OP_STORE      = 3'd3,
    OP_STORE_BYTE = 3'd4,
    OP_ACC        = 3'd5,
    OP_INT        = 3'd6
  } op_t;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE     = 3'd1,
    S_MEM_WAIT = 3'd2,
    S_ACC_WAIT = 3'd3,
    S_INT_WAIT = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/agp32_byte_lane.sv
// Combinational byte-lane helper: store strobe/replication and load byte extraction.
// Purely a function of its inputs; the sequencer registers the results.
module agp32_byte_lane
  import agp32_mem_seq_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int LANES  = DATA_W / 8,
  localparam int LANE_W = width_min1(LANES)
) (
  input  logic [LANE_W-1:0] st_lane,
  input  logic [7:0]        st_byte,
  output logic [LANES-1:0]  st_strb,
  output logic [DATA_W-1:0] st_data,
  input  logic [LANE_W-1:0] ld_lane,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] ld_byte
);

  always_comb begin
    st_strb = '0;
    st_data = '0;
    ld_byte = '0;
    for (int i = 0; i < LANES; i++) begin
      st_strb[i]        = (st_lane == LANE_W'(i));
      st_data[i*8 +: 8] = st_byte;
      if (ld_lane == LANE_W'(i)) ld_byte[7:0] = ld_data[i*8 +: 8];
    end
  end

endmodule

// File: rtl/agp32_mem_seq.sv
// agp32 MEM-stage sequencer: one request at a time to bus, accelerators or interrupts.
// Optional watchdog enabled by defining AGP32_MEM_SEQ_TIMEOUT_EN.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE with mem_ready=1, and fields must be stable while valid.
module agp32_mem_seq
  import agp32_mem_seq_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int ADDR_W      = 32,
  parameter  int ACC_CH      = 2,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int SEL_W       = width_min1(ACC_CH),
  localparam int LANES       = DATA_W / 8,
  localparam int LANE_W      = width_min1(LANES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [SEL_W-1:0]         req_acc_sel,
  input  logic                     mem_start_ready,
  input  logic                     mem_ready,
  input  logic [1:0]               mem_error,
  output cmd_t                     command,
  output logic [ADDR_W-1:0]        data_addr,
  output logic [DATA_W-1:0]        data_wdata,
  output logic [LANES-1:0]         data_wstrb,
  input  logic [DATA_W-1:0]        data_rdata,
  output logic [DATA_W-1:0]        acc_arg,
  output logic [ACC_CH-1:0]        acc_arg_valid,
  input  logic [ACC_CH*DATA_W-1:0] acc_res,
  input  logic [ACC_CH-1:0]        acc_res_valid,
  output logic                     interrupt_req,
  input  logic                     interrupt_ack,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     fault,
  output state_t                   dbg_state
);

  state_t              state, state_n;
  op_t                 op_q, op_n;
  logic [LANE_W-1:0]   lane_q, lane_n;
  logic [ACC_CH-1:0]   sel_q, sel_n;
  logic                int_pend, int_pend_n;
  logic                silent, silent_n;
  cmd_t                command_n;
  logic [ADDR_W-1:0]   data_addr_n;
  logic [DATA_W-1:0]   data_wdata_n;
  logic [LANES-1:0]    data_wstrb_n;
  logic [DATA_W-1:0]   acc_arg_n;
  logic [ACC_CH-1:0]   acc_arg_valid_n;
  logic                interrupt_req_n;
  logic                rsp_valid_n;
  logic [DATA_W-1:0]   rsp_data_n;
  logic                fault_n;
  logic                wd_expire;

  logic [LANE_W-1:0]   req_lane;
  logic [ACC_CH-1:0]   req_sel_onehot;
  logic [LANES-1:0]    st_strb;
  logic [DATA_W-1:0]   st_data;
  logic [DATA_W-1:0]   ld_byte;
  logic [DATA_W-1:0]   acc_pick;
  logic                acc_hit;

  assign req_ready = (state == S_IDLE) && mem_ready;
  assign dbg_state = state;
  assign req_lane  = (LANES > 1) ? req_addr[LANE_W-1:0] : '0;

  agp32_byte_lane #(.DATA_W(DATA_W)) u_lane (
    .st_lane (req_lane),
    .st_byte (req_wdata[7:0]),
    .st_strb (st_strb),
    .st_data (st_data),
    .ld_lane (lane_q),
    .ld_data (data_rdata),
    .ld_byte (ld_byte)
  );

  // Channel selection kept one-hot so out-of-range selects simply match nothing.
  always_comb begin
    req_sel_onehot = '0;
    acc_pick       = '0;
    for (int i = 0; i < ACC_CH; i++) begin
      req_sel_onehot[i] = (req_acc_sel == SEL_W'(i));
      if (sel_q[i]) acc_pick = acc_pick | acc_res[i*DATA_W +: DATA_W];
    end
    acc_hit = |(acc_res_valid & sel_q);
  end

`ifdef AGP32_MEM_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            in_wait;

  assign in_wait   = (state == S_MEM_WAIT) || (state == S_ACC_WAIT) || (state == S_INT_WAIT);
  assign wd_expire = in_wait && ((wd_cnt + 1'b1) == WD_W'(TIMEOUT_CYC));

  // Restarts on every entry into a wait state, including MEM_WAIT -> INT_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          wd_cnt <= '0;
    else if (!in_wait || state_n != state) wd_cnt <= '0;
    else                                 wd_cnt <= wd_cnt + 1'b1;
  end
`else
  // Watchdog absent: wait states never time out.
  assign wd_expire = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_n         = state;
    op_n            = op_q;
    lane_n          = lane_q;
    sel_n           = sel_q;
    int_pend_n      = int_pend;
    silent_n        = silent;
    command_n       = CMD_NONE;
    data_addr_n     = data_addr;
    data_wdata_n    = data_wdata;
    data_wstrb_n    = data_wstrb;
    acc_arg_n       = acc_arg;
    acc_arg_valid_n = '0;
    interrupt_req_n = interrupt_req;
    rsp_valid_n     = 1'b0;
    rsp_data_n      = rsp_data;
    fault_n         = fault;

    case (state)
      S_INIT: begin
        if (mem_start_ready) begin
          command_n  = CMD_REFRESH;
          silent_n   = 1'b1;
          int_pend_n = 1'b0;
          state_n    = S_MEM_WAIT;
        end
      end

      S_IDLE: begin
        if (req_valid && req_ready) begin
          op_n       = op_t'(req_op);
          lane_n     = req_lane;
          sel_n      = req_sel_onehot;
          int_pend_n = 1'b0;
          silent_n   = 1'b0;
          case (op_t'(req_op))
            OP_LOAD, OP_LOAD_BYTE: begin
              command_n   = CMD_READ;
              data_addr_n = req_addr;
              state_n     = S_MEM_WAIT;
            end
            OP_STORE: begin
              command_n    = CMD_WRITE;
              data_addr_n  = req_addr;
              data_wdata_n = req_wdata;
              data_wstrb_n = '1;
              state_n      = S_MEM_WAIT;
            end
            OP_STORE_BYTE: begin
              command_n    = CMD_WRITE;
              data_addr_n  = req_addr;
              data_wdata_n = st_data;
              data_wstrb_n = st_strb;
              state_n      = S_MEM_WAIT;
            end
            OP_ACC: begin
              acc_arg_n       = req_wdata;
              acc_arg_valid_n = req_sel_onehot;
              state_n         = S_ACC_WAIT;
            end
            OP_INT: begin
              command_n   = CMD_INTERRUPT;
              data_addr_n = '0;
              int_pend_n  = 1'b1;
              state_n     = S_MEM_WAIT;
            end
            default: begin
              rsp_valid_n = 1'b1;
              rsp_data_n  = '0;
            end
          endcase
        end
      end

      // The issue cycle still shows the command, so it can never count as completion.
      S_MEM_WAIT: begin
        if (mem_ready && command == CMD_NONE) begin
          if (int_pend) begin
            interrupt_req_n = 1'b1;
            state_n         = S_INT_WAIT;
          end else begin
            state_n = S_IDLE;
            if (!silent) begin
              rsp_valid_n = 1'b1;
              case (op_q)
                OP_LOAD:      rsp_data_n = data_rdata;
                OP_LOAD_BYTE: rsp_data_n = ld_byte;
                default:      rsp_data_n = '0;
              endcase
            end
          end
        end
      end

      // Valid seen during the argument pulse belongs to an older transaction.
      S_ACC_WAIT: begin
        if (acc_arg_valid == '0 && acc_hit) begin
          rsp_valid_n = 1'b1;
          rsp_data_n  = acc_pick;
          state_n     = S_IDLE;
        end
      end

      S_INT_WAIT: begin
        if (interrupt_ack) begin
          interrupt_req_n = 1'b0;
          rsp_valid_n     = 1'b1;
          rsp_data_n      = '0;
          state_n         = S_IDLE;
        end
      end

      S_ERROR: ;

      default: state_n = S_ERROR;
    endcase

    if (mem_error != 2'b00 || wd_expire) begin
      state_n         = S_ERROR;
      fault_n         = 1'b1;
      command_n       = CMD_NONE;
      acc_arg_valid_n = '0;
      interrupt_req_n = 1'b0;
      rsp_valid_n     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_INIT;
      op_q          <= OP_NONE;
      lane_q        <= '0;
      sel_q         <= '0;
      int_pend      <= 1'b0;
      silent        <= 1'b0;
      command       <= CMD_NONE;
      data_addr     <= '1;
      data_wdata    <= '0;
      data_wstrb    <= '0;
      acc_arg       <= '0;
      acc_arg_valid <= '0;
      interrupt_req <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      fault         <= 1'b0;
    end else begin
      state         <= state_n;
      op_q          <= op_n;
      lane_q        <= lane_n;
      sel_q         <= sel_n;
      int_pend      <= int_pend_n;
      silent        <= silent_n;
      command       <= command_n;
      data_addr     <= data_addr_n;
      data_wdata    <= data_wdata_n;
      data_wstrb    <= data_wstrb_n;
      acc_arg       <= acc_arg_n;
      acc_arg_valid <= acc_arg_valid_n;
      interrupt_req <= interrupt_req_n;
      rsp_valid     <= rsp_valid_n;
      rsp_data      <= rsp_data_n;
      fault         <= fault_n;
    end
  end

endmodule

// File: tb/tb_agp32_mem_seq.sv
// Directed bench for agp32_mem_seq: start-up, byte/word load-store, accelerator,
// interrupt, sticky error, watchdog (or its absence) and mid-operation reset.
module tb_agp32_mem_seq;
  import agp32_mem_seq_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int ACC_CH = 2;

  logic                     clk;
  logic                     rst_n;
  logic                     req_valid;
  logic                     req_ready;
  logic [2:0]               req_op;
  logic [ADDR_W-1:0]        req_addr;
  logic [DATA_W-1:0]        req_wdata;
  logic [0:0]               req_acc_sel;
  logic                     mem_start_ready;
  logic                     mem_ready;
  logic [1:0]               mem_error;
  cmd_t                     command;
  logic [ADDR_W-1:0]        data_addr;
  logic [DATA_W-1:0]        data_wdata;
  logic [DATA_W/8-1:0]      data_wstrb;
  logic [DATA_W-1:0]        data_rdata;
  logic [DATA_W-1:0]        acc_arg;
  logic [ACC_CH-1:0]        acc_arg_valid;
  logic [ACC_CH*DATA_W-1:0] acc_res;
  logic [ACC_CH-1:0]        acc_res_valid;
  logic                     interrupt_req;
  logic                     interrupt_ack;
  logic                     rsp_valid;
  logic [DATA_W-1:0]        rsp_data;
  logic                     fault;
  state_t                   dbg_state;

  int checks;
  int failures;

  agp32_mem_seq #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_CH(ACC_CH), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_acc_sel(req_acc_sel),
    .mem_start_ready(mem_start_ready), .mem_ready(mem_ready), .mem_error(mem_error),
    .command(command), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_rdata(data_rdata),
    .acc_arg(acc_arg), .acc_arg_valid(acc_arg_valid),
    .acc_res(acc_res), .acc_res_valid(acc_res_valid),
    .interrupt_req(interrupt_req), .interrupt_ack(interrupt_ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .fault(fault), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: presents one request for a single accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic sel);
    req_valid   = 1'b1;
    req_op      = op;
    req_addr    = addr;
    req_wdata   = wdata;
    req_acc_sel = sel;
    tick();
    req_valid   = 1'b0;
    req_op      = 3'd0;
  endtask

  task automatic startup();
    rst_n = 1'b1;
    tick();
    tick();
    mem_start_ready = 1'b1;
    tick();
    chk("start_cmd_refresh", command, 3'd1);
    chk("start_state_memwait", dbg_state, S_MEM_WAIT);
    mem_start_ready = 1'b0;
    mem_ready       = 1'b1;
    tick();
    chk("start_cmd_none", command, 3'd0);
    chk("start_no_rsp_a", rsp_valid, 1'b0);
    tick();
    chk("start_state_idle", dbg_state, S_IDLE);
    chk("start_no_rsp_b", rsp_valid, 1'b0);
    chk("start_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = '0; req_acc_sel = 1'b0;
    mem_start_ready = 1'b0; mem_ready = 1'b0; mem_error = 2'b00;
    data_rdata = '0; acc_res = '0; acc_res_valid = '0; interrupt_ack = 1'b0;
    tick();
    tick();
    tick();

    chk("rst_state", dbg_state, S_INIT);
    chk("rst_command", command, 3'd0);
    chk("rst_data_addr", data_addr, 32'hFFFF_FFFF);
    chk("rst_wdata", data_wdata, 32'h0);
    chk("rst_wstrb", data_wstrb, 4'h0);
    chk("rst_acc", {acc_arg, acc_arg_valid}, 34'h0);
    chk("rst_rsp", {rsp_valid, rsp_data}, 33'h0);
    chk("rst_fault_intr", {fault, interrupt_req}, 2'b00);
    chk("rst_req_ready", req_ready, 1'b0);

    startup();

    // Byte load from lane 2
    data_rdata = 32'hAABB_CCDD;
    issue(3'd2, 32'h0000_1002, 32'h0, 1'b0);
    chk("lb_cmd", command, 3'd2);
    chk("lb_addr", data_addr, 32'h0000_1002);
    chk("lb_req_ready_low", req_ready, 1'b0);
    tick();
    chk("lb_cmd_none", command, 3'd0);
    chk("lb_no_early_rsp", rsp_valid, 1'b0);
    tick();
    chk("lb_rsp_valid", rsp_valid, 1'b1);
    chk("lb_rsp_data", rsp_data, 32'h0000_00BB);
    tick();
    chk("lb_rsp_one_cycle", rsp_valid, 1'b0);

    // Byte store to lane 3
    issue(3'd4, 32'h0000_0203, 32'h0000_005A, 1'b0);
    chk("sb_cmd", command, 3'd3);
    chk("sb_wstrb", data_wstrb, 4'b1000);
    chk("sb_wdata", data_wdata, 32'h5A5A_5A5A);
    chk("sb_addr", data_addr, 32'h0000_0203);
    tick();
    tick();
    chk("sb_rsp", {rsp_valid, rsp_data}, {1'b1, 32'h0});
    tick();

    // Word store with delayed bus completion
    issue(3'd3, 32'h0000_0040, 32'h1234_5678, 1'b0);
    chk("st_cmd", command, 3'd3);
    chk("st_wstrb", data_wstrb, 4'hF);
    chk("st_wdata", data_wdata, 32'h1234_5678);
    mem_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("st_wait_no_rsp", rsp_valid, 1'b0);
    chk("st_wait_state", dbg_state, S_MEM_WAIT);
    mem_ready = 1'b1;
    tick();
    chk("st_rsp", {rsp_valid, rsp_data}, {1'b1, 32'h0});

    // Word load accepted in the response cycle
    data_rdata = 32'h0BAD_F00D;
    issue(3'd1, 32'h0000_0044, 32'h0, 1'b0);
    chk("ld_cmd", command, 3'd2);
    tick();
    tick();
    chk("ld_rsp", {rsp_valid, rsp_data}, {1'b1, 32'h0BAD_F00D});

    // NONE and reserved op 7 answer next cycle with zero
    issue(3'd0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    chk("none_rsp", {rsp_valid, rsp_data}, {1'b1, 32'h0});
    chk("none_state", dbg_state, S_IDLE);
    chk("none_cmd", command, 3'd0);
    tick();
    issue(3'd7, 32'h0, 32'h0, 1'b0);
    chk("op7_rsp", {rsp_valid, rsp_data}, {1'b1, 32'h0});

    // Accelerator channel 1 with a stale valid during the pulse
    issue(3'd5, 32'h0, 32'h0003_0004, 1'b1);
    chk("acc_pulse", acc_arg_valid, 2'b10);
    chk("acc_arg", acc_arg, 32'h0003_0004);
    chk("acc_state", dbg_state, S_ACC_WAIT);
    acc_res_valid = 2'b10;
    acc_res       = {32'h0000_DEAD, 32'h0};
    tick();
    chk("acc_pulse_drop", acc_arg_valid, 2'b00);
    chk("acc_stale_ignored", rsp_valid, 1'b0);
    acc_res_valid = 2'b01;
    acc_res       = {32'h0, 32'h0000_BEEF};
    tick();
    chk("acc_other_ch_ignored", rsp_valid, 1'b0);
    acc_res_valid = 2'b00;
    tick();
    tick();
    chk("acc_still_wait", dbg_state, S_ACC_WAIT);
    acc_res_valid = 2'b10;
    acc_res       = {32'h0000_0007, 32'h0};
    tick();
    acc_res_valid = 2'b00;
    chk("acc_rsp", {rsp_valid, rsp_data}, {1'b1, 32'h7});
    tick();
    chk("acc_rsp_once", rsp_valid, 1'b0);

    // Interrupt
    issue(3'd6, 32'h0000_1234, 32'h0, 1'b0);
    chk("int_cmd", command, 3'd4);
    chk("int_addr", data_addr, 32'h0);
    chk("int_req_low", interrupt_req, 1'b0);
    tick();
    tick();
    chk("int_req_high", interrupt_req, 1'b1);
    chk("int_no_rsp", rsp_valid, 1'b0);
    chk("int_state", dbg_state, S_INT_WAIT);
    tick();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    chk("int_ack_rsp", {rsp_valid, rsp_data, interrupt_req}, {1'b1, 32'h0, 1'b0});

    // Bus error coinciding with completion
    issue(3'd1, 32'h0000_0080, 32'h0, 1'b0);
    chk("err_cmd", command, 3'd2);
    tick();
    mem_error = 2'b01;
    tick();
    mem_error = 2'b00;
    chk("err_fault", fault, 1'b1);
    chk("err_no_rsp", rsp_valid, 1'b0);
    chk("err_state", dbg_state, S_ERROR);
    chk("err_req_ready", req_ready, 1'b0);
    req_valid = 1'b1;
    tick();
    tick();
    tick();
    req_valid = 1'b0;
    chk("err_sticky", {fault, req_ready, rsp_valid, command}, {1'b1, 1'b0, 1'b0, 3'd0});

    // Reset clears the fault
    rst_n = 1'b0;
    #2;
    chk("rst2_fault", fault, 1'b0);
    chk("rst2_state", dbg_state, S_INIT);
    tick();
    startup();

    // Watchdog behaviour while the bus never completes
    issue(3'd1, 32'h0000_0100, 32'h0, 1'b0);
    mem_ready = 1'b0;
`ifdef AGP32_MEM_SEQ_TIMEOUT_EN
    for (int k = 1; k < 16; k++) tick();
    chk("wd_before_limit", fault, 1'b0);
    tick();
    chk("wd_fault_at_16", fault, 1'b1);
    chk("wd_state", dbg_state, S_ERROR);
`else
    for (int k = 0; k < 100; k++) tick();
    chk("nowd_still_wait", dbg_state, S_MEM_WAIT);
    chk("nowd_no_fault", {fault, rsp_valid}, 2'b00);
`endif

    // Reset mid-operation discards the request
    rst_n = 1'b0;
    #2;
    chk("midrst_outputs", {rsp_valid, command, fault, interrupt_req}, {1'b0, 3'd0, 1'b0, 1'b0});
    chk("midrst_addr", data_addr, 32'hFFFF_FFFF);
    mem_ready = 1'b1;
    tick();
    chk("midrst_no_rsp", {rsp_valid, dbg_state}, {1'b0, S_INIT});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
